// File: rtl/four_bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_serial_adder
// Brief    : Bit-serial adder S = A + B + Cin using one shared full-adder
//            slice, one bit per clock, with a start/busy/done handshake.
//            Also serves as the inverse of the 4-bit ripple subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             c_q, c_d;
    logic             c_msb_q, c_msb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    // Single shared full-adder slice working on the current LSBs.
    logic w_bit_sum;
    logic w_bit_carry;
    logic w_last_bit;

    assign w_bit_sum   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign w_bit_carry = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & c_q) | (a_sh_q[0] & c_q);
    assign w_last_bit  = (cnt_q == C_LAST_BIT);

    // FSM state register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE; DONE always returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (w_last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Datapath next values: load on accepted start, shift one bit per RUN edge.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        c_msb_d = c_msb_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d = A;
                    b_sh_d = B;
                    c_d    = Cin;
                    cnt_d  = '0;
                end
            end
            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d = {w_bit_sum, s_sh_q[WIDTH-1:1]};
                c_d    = w_bit_carry;
                cnt_d  = cnt_q + CNT_W'(1);
                if (w_last_bit) begin
                    // The carry entering the MSB slice is the carry held now.
                    c_msb_d = c_q;
                    s_d     = {w_bit_sum, s_sh_q[WIDTH-1:1]};
                    cout_d  = w_bit_carry;
                    v_d     = c_msb_d ^ w_bit_carry;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and result registers; results only move on the RUN->DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            c_msb_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            c_msb_q <= c_msb_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule
`default_nettype wire

// File: doc/four_bit_serial_adder.md
# four_bit_serial_adder

Bit-serial, multi-cycle adder and the inverse datapath of the team's 4-bit ripple-carry subtractor. It computes S = A + B + Cin one bit per clock with a single shared full-adder slice and a start/busy/done handshake. Feeding it a subtractor difference and subtrahend recovers the original minuend. It sits next to the subtractor in the ALU datapath, where area matters more than latency.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  addend, captured on the accepted start edge
- B  input  WIDTH  addend, captured on the accepted start edge
- Cin  input  1  carry-in, captured on the accepted start edge
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; result valid from this cycle on
- S  output  WIDTH  registered sum, held until the next completion
- Cout  output  1  registered carry out of the MSB
- V  output  1  registered signed overflow (carry into MSB XOR Cout)

## Operation
- Internal state: a_sh, b_sh and s_sh (each WIDTH bits); carry flop c; carry-into-MSB flop c_msb; bit counter cnt (clog2(WIDTH) bits); FSM with states IDLE, RUN and DONE.
- IDLE behaviour with start=1:
  - load a_sh=A, b_sh=B, c=Cin, cnt=0
  - move to RUN
- IDLE behaviour with start=0: stay in IDLE.
- RUN, each edge:
  - sum = a_sh[0]^b_sh[0]^c
  - c <= a_sh[0]&b_sh[0] | b_sh[0]&c | a_sh[0]&c
  - shift a_sh and b_sh right; shift sum into s_sh MSB (right shift)
  - on the edge where cnt==WIDTH-1, first set c_msb <= c (old value)
  - cnt <= cnt+1
- RUN exit, on the edge processing cnt==WIDTH-1:
  - S <= final s_sh (including this bit), Cout <= new carry, V <= c_msb ^ new carry
  - move to DONE
- DONE:
  - done=1 for exactly one cycle
  - unconditionally move to IDLE
  - start during DONE is ignored
- start during RUN or DONE is ignored; the operands in flight are unaffected.
- Arithmetic is unsigned modulo 2^WIDTH with Cout. V gives the two's-complement overflow of the same sum.
- S, Cout and V change only on the RUN→DONE edge. They never show partial results.
- Reset, in any state and at any time:
  - state=IDLE
  - S=0, Cout=0, V=0, busy=0, done=0
  - shift registers, c, c_msb and cnt cleared
  - an operation in progress is discarded with no done pulse

## Timing
- Reset values: busy=0, done=0, S=0, Cout=0, V=0.
- Start accepted at edge t (state IDLE, start=1):
  - busy=1 for cycles after edges t .. t+WIDTH-1
  - bits are processed on edges t+1 .. t+WIDTH
  - S, Cout and V update at edge t+WIDTH; done=1 in the cycle after edge t+WIDTH
  - done falls and state returns to IDLE at edge t+WIDTH+1
- Latency from the start edge to the result: WIDTH cycles. Minimum start-to-start spacing: WIDTH+2 cycles (start must arrive in IDLE).
- busy and done are never high together. done is registered, not combinational from start.
- start held high continuously: a new operation begins at each IDLE cycle, i.e. every WIDTH+2 cycles.
- Reset deasserted with start=1: the first accepted start is the first edge after deassertion with rst=0.

## Test plan
- A=5, B=3, Cin=0 → after 4 cycles done pulses; S=8, Cout=0, V=1.
- A=15, B=1, Cin=0 → S=0, Cout=1, V=0. A=8, B=8 → S=0, Cout=1, V=1.
- Inverse check: subtractor (9−3) gives 6; here A=6, B=3, Cin=0 → S=9, Cout=0. A=0, B=0, Cin=1 → S=1.
- Start with A=7, B=7. Pulse start with A=1, B=1 at cycle 2 of RUN. → ignored; result S=14, exactly one done pulse.
- Start, assert rst at RUN cycle 2 → all outputs 0 immediately (async), no done. A new start after release with A=2, B=2 → S=4.
- Randomized: all 512 combinations of A, B and Cin (WIDTH=4) checked against the reference model A+B+Cin for S, Cout and V. Check latency = 4 and busy/done are mutually exclusive.
